// File: rtl/fan_batch_sched_if.sv
// Purpose: handshake bundle between an element source, fan_batch_sched and the fan reduction network.
// Ports:   input stream (in_valid/in_ready/in_data/in_row/in_last), lane vector out (out_valid/out_ready/out_line),
//          tile_done pulse and batch_cnt status. slave = scheduler side, master = testbench/upstream side.
interface fan_batch_sched_if #(
  parameter int N_STACK = 4,
  parameter int DW_DATA = 32,
  parameter int DW_ROW  = 4,
  parameter int NUM_IN  = 8
) ();
  localparam int DW_LINE = N_STACK*DW_DATA + DW_ROW + 4;

  logic                        in_valid;
  logic                        in_ready;
  logic [N_STACK*DW_DATA-1:0]  in_data;
  logic [DW_ROW-1:0]           in_row;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_IN*DW_LINE-1:0]   out_line;
  logic                        tile_done;
  logic [15:0]                 batch_cnt;

  modport slave (
    input  in_valid, in_data, in_row, in_last, out_ready,
    output in_ready, out_valid, out_line, tile_done, batch_cnt
  );

  modport master (
    output in_valid, in_data, in_row, in_last, out_ready,
    input  in_ready, out_valid, out_line, tile_done, batch_cnt
  );
endinterface

// File: rtl/fan_batch_sched.sv
// Purpose: packs up to NUM_IN row-tagged stacks into one lane vector with per-lane ctrl nibbles
//          {valid, keep, seg_start, seg_end}, issues it, and signals tile_done after the network drains.
// Latency: out_valid rises the cycle after the closing accept (or FLUSH_TIMEOUT+1 cycles after the last accept).
// Backpressure: in_ready is low outside FILL; out_line is held while out_valid & !out_ready.
// Ports: clk, rst_n (async, active-low) and the slave side of fan_batch_sched_if; all outputs registered.
module fan_batch_sched #(
  parameter int N_STACK       = 4,
  parameter int DW_DATA       = 32,
  parameter int DW_ROW        = 4,
  parameter int NUM_IN        = 8,
  parameter int FAN_LAT       = 3,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fan_batch_sched_if.slave    bus
);
  localparam int DW_STK  = N_STACK*DW_DATA;
  localparam int DW_LINE = DW_STK + DW_ROW + 4;
  localparam int CW      = $clog2(NUM_IN+1);
  localparam int TW      = $clog2(FLUSH_TIMEOUT+2);
  localparam int DRW     = $clog2(FAN_LAT+1);

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_DRAIN} state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DW_ROW-1:0]        lane_row_q [NUM_IN];
  logic [DW_ROW-1:0]        lane_row_d [NUM_IN];
  logic [DW_STK-1:0]        lane_dat_q [NUM_IN];
  logic [DW_STK-1:0]        lane_dat_d [NUM_IN];
  logic                     last_q;
  logic [TW-1:0]            to_q;
  logic [DRW-1:0]           drn_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [NUM_IN*DW_LINE-1:0] out_line_q, line_d;
  logic                     tile_done_q;
  logic [15:0]              batch_cnt_q;

  logic                     acc;
  logic                     close_acc;
  logic                     flush;
  logic [NUM_IN:0]          row_chg;

  assign acc       = (state_q == S_FILL) && bus.in_valid && in_ready_q;
  assign close_acc = acc && ((cnt_d == CW'(NUM_IN)) || bus.in_last);
  assign flush     = (state_q == S_FILL) && !acc && (cnt_q != '0) &&
                     (FLUSH_TIMEOUT != 0) && (to_q == TW'(FLUSH_TIMEOUT));

  // Buffer contents as they will be after this cycle's accept, so the closing
  // element is already part of the vector registered on entry to ISSUE.
  always_comb begin
    lane_row_d = lane_row_q;
    lane_dat_d = lane_dat_q;
    cnt_d      = cnt_q;
    if (acc) cnt_d = cnt_q + CW'(1);
    for (int i = 0; i < NUM_IN; i++) begin
      if (acc && (cnt_q == CW'(i))) begin
        lane_row_d[i] = bus.in_row;
        lane_dat_d[i] = bus.in_data;
      end
    end
  end

  // row_chg[i] marks a segment boundary between lane i-1 and lane i; the two
  // outer positions are always boundaries so lane 0 starts and lane NUM_IN-1 ends.
  always_comb begin
    row_chg         = '0;
    row_chg[0]      = 1'b1;
    row_chg[NUM_IN] = 1'b1;
    for (int i = 1; i < NUM_IN; i++) begin
      row_chg[i] = (lane_row_d[i] != lane_row_d[i-1]);
    end
    line_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (i < int'(cnt_d)) begin
        line_d[i*DW_LINE +: DW_LINE] = {2'b11, row_chg[i],
                                        (i == int'(cnt_d) - 1) | row_chg[i+1],
                                        lane_row_d[i], lane_dat_d[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        lane_row_q[i] <= '0;
        lane_dat_q[i] <= '0;
      end
      last_q      <= 1'b0;
      to_q        <= '0;
      drn_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_line_q  <= '0;
      tile_done_q <= 1'b0;
      batch_cnt_q <= '0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          lane_row_q <= lane_row_d;
          lane_dat_q <= lane_dat_d;
          cnt_q      <= cnt_d;
          if (acc) begin
            to_q <= '0;
            if (bus.in_last) last_q <= 1'b1;
          end else if ((cnt_q != '0) && (FLUSH_TIMEOUT != 0)) begin
            to_q <= to_q + TW'(1);
          end
          if (close_acc || flush) begin
            state_q     <= S_ISSUE;
            out_line_q  <= line_d;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            to_q        <= '0;
          end else begin
            // Also re-opens the input one cycle after the tile_done pulse.
            in_ready_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            batch_cnt_q <= batch_cnt_q + 16'd1;
            cnt_q       <= '0;
            if (last_q) begin
              state_q <= S_DRAIN;
              drn_q   <= DRW'(FAN_LAT);
              last_q  <= 1'b0;
            end else begin
              state_q    <= S_FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drn_q == '0) begin
            tile_done_q <= 1'b1;
            state_q     <= S_FILL;
          end else begin
            drn_q <= drn_q - DRW'(1);
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_line  = out_line_q;
  assign bus.tile_done = tile_done_q;
  assign bus.batch_cnt = batch_cnt_q;
endmodule

// File: tb/tb_fan_batch_sched.sv
// Directed bench for fan_batch_sched: reset, full/partial/last batches, backpressure,
// timeout flush, in_last on a full batch, asynchronous reset during ISSUE and batch_cnt wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_fan_batch_sched;
  localparam int N_STACK       = 4;
  localparam int DW_DATA       = 32;
  localparam int DW_ROW        = 4;
  localparam int NUM_IN        = 8;
  localparam int FAN_LAT       = 3;
  localparam int FLUSH_TIMEOUT = 16;
  localparam int DW_LINE       = N_STACK*DW_DATA + DW_ROW + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fan_batch_sched_if #(.N_STACK(N_STACK), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .NUM_IN(NUM_IN)) bus ();

  fan_batch_sched #(
    .N_STACK(N_STACK), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .NUM_IN(NUM_IN),
    .FAN_LAT(FAN_LAT), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW_LINE-1:0] obs, input logic [DW_LINE-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW_LINE-1:0] lane(input int i);
    return bus.out_line[i*DW_LINE +: DW_LINE];
  endfunction

  task automatic chk_ctrl(input string tag, input int i, input logic [3:0] exp);
    logic [DW_LINE-1:0] l;
    l = lane(i);
    chk($sformatf("%s_ctrl%0d", tag, i), l[DW_LINE-1 -: 4], exp);
  endtask

  task automatic send(input logic [DW_ROW-1:0] row, input logic [DW_DATA-1:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    bus.in_data  = {N_STACK{d}};
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  logic [3:0]        rows_a [NUM_IN];
  logic [3:0]        exp_a  [NUM_IN];
  logic [3:0]        exp_c  [NUM_IN];
  logic [DW_LINE-1:0] l;
  logic              seen_td;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_row    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rows_a = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3};
    exp_a  = '{4'hE, 4'hD, 4'hE, 4'hC, 4'hD, 4'hF, 4'hE, 4'hD};
    exp_c  = '{4'hE, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hD};

    // Reset state
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_line",  {135'd0, |bus.out_line}, '0);
    chk("rst_tile_done", bus.tile_done, 1'b0);
    chk("rst_batch_cnt", bus.batch_cnt, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Full batch, rows 0,0,1,1,1,2,3,3
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (i == NUM_IN-1) chk("full_no_early_valid", bus.out_valid, 1'b0);
      send(rows_a[i], 32'h100 + i, 1'b0);
    end
    chk("full_out_valid", bus.out_valid, 1'b1);
    chk("full_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < NUM_IN; i++) chk_ctrl("full", i, exp_a[i]);
    l = lane(5);
    chk("full_row5", l[DW_LINE-5 -: 4], 4'd2);
    l = lane(3);
    chk("full_data3", l[DW_DATA-1:0], 32'h103);
    chk("full_data3_top", l[N_STACK*DW_DATA-1 -: DW_DATA], 32'h103);
    tick();
    chk("full_batch_cnt", bus.batch_cnt, 16'd1);
    chk("full_valid_drop", bus.out_valid, 1'b0);
    chk("full_in_ready_back", bus.in_ready, 1'b1);

    // Backpressure: all rows 7, out_ready low for 10 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) send(4'd7, 32'h200 + i, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_batch_cnt", bus.batch_cnt, 16'd1);
      chk_ctrl("bp", 0, exp_c[0]);
      chk_ctrl("bp", 7, exp_c[7]);
      l = lane(6);
      chk("bp_data6", l[DW_DATA-1:0], 32'h206);
      tick();
    end
    for (int i = 1; i < NUM_IN-1; i++) chk_ctrl("bp", i, exp_c[i]);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_batch_cnt_inc", bus.batch_cnt, 16'd2);
    chk("bp_valid_drop", bus.out_valid, 1'b0);

    // Three elements rows 5,5,5 with in_last, then drain
    send(4'd5, 32'h300, 1'b0);
    send(4'd5, 32'h301, 1'b0);
    send(4'd5, 32'h302, 1'b1);
    chk("last3_out_valid", bus.out_valid, 1'b1);
    chk_ctrl("last3", 0, 4'hE);
    chk_ctrl("last3", 1, 4'hC);
    chk_ctrl("last3", 2, 4'hD);
    for (int i = 3; i < NUM_IN; i++) chk($sformatf("last3_lane%0d_zero", i), lane(i), '0);
    tick();
    chk("last3_batch_cnt", bus.batch_cnt, 16'd3);
    chk("last3_in_ready_drain", bus.in_ready, 1'b0);
    for (int k = 1; k <= FAN_LAT; k++) begin
      tick();
      chk($sformatf("last3_no_td_%0d", k), bus.tile_done, 1'b0);
    end
    tick();
    chk("last3_tile_done", bus.tile_done, 1'b1);
    chk("last3_in_ready_at_td", bus.in_ready, 1'b0);
    tick();
    chk("last3_td_one_cycle", bus.tile_done, 1'b0);
    chk("last3_in_ready_back", bus.in_ready, 1'b1);

    // Timeout flush of a two-element batch
    send(4'd1, 32'h400, 1'b0);
    send(4'd2, 32'h401, 1'b0);
    for (int k = 0; k < FLUSH_TIMEOUT; k++) tick();
    chk("to_not_yet", bus.out_valid, 1'b0);
    tick();
    chk("to_out_valid", bus.out_valid, 1'b1);
    chk_ctrl("to", 0, 4'hF);
    chk_ctrl("to", 1, 4'hF);
    chk("to_lane2_zero", lane(2), '0);
    tick();
    chk("to_batch_cnt", bus.batch_cnt, 16'd4);
    seen_td = 1'b0;
    for (int k = 0; k < FAN_LAT+3; k++) begin
      seen_td |= bus.tile_done;
      tick();
    end
    chk("to_no_tile_done", seen_td, 1'b0);
    chk("to_in_ready", bus.in_ready, 1'b1);

    // in_last on the element that fills the buffer: one batch, rows 0..7
    for (int i = 0; i < NUM_IN; i++) send(i[3:0], 32'h500 + i, (i == NUM_IN-1));
    chk("lastfull_out_valid", bus.out_valid, 1'b1);
    chk_ctrl("lastfull", 0, 4'hF);
    chk_ctrl("lastfull", 7, 4'hF);
    tick();
    chk("lastfull_batch_cnt", bus.batch_cnt, 16'd5);
    for (int k = 0; k < FAN_LAT; k++) tick();
    tick();
    chk("lastfull_tile_done", bus.tile_done, 1'b1);
    tick();
    chk("lastfull_no_empty_batch", bus.out_valid, 1'b0);
    chk("lastfull_batch_cnt_hold", bus.batch_cnt, 16'd5);

    // Asynchronous reset while in ISSUE
    bus.out_ready = 1'b0;
    send(4'd9, 32'h600, 1'b1);
    chk("arst_pre_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_line", {135'd0, |bus.out_line}, '0);
    chk("arst_batch_cnt", bus.batch_cnt, 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_in_ready", bus.in_ready, 1'b1);
    seen_td = 1'b0;
    for (int k = 0; k < FAN_LAT+3; k++) begin
      seen_td |= bus.tile_done;
      tick();
    end
    chk("arst_no_tile_done", seen_td, 1'b0);
    chk("arst_no_valid", bus.out_valid, 1'b0);

    // batch_cnt wrap from 0xFFFF
    force dut.batch_cnt_q = 16'hFFFF;
    #1;
    release dut.batch_cnt_q;
    #1;
    chk("wrap_preload", bus.batch_cnt, 16'hFFFF);
    bus.out_ready = 1'b1;
    tick();
    send(4'd3, 32'h700, 1'b1);
    chk("wrap_one_elem_valid", bus.out_valid, 1'b1);
    chk_ctrl("wrap", 0, 4'hF);
    chk("wrap_lane1_zero", lane(1), '0);
    tick();
    chk("wrap_batch_cnt", bus.batch_cnt, 16'h0000);
    for (int k = 0; k < FAN_LAT+2; k++) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
